// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl codes, FSM state type and shift-code helper shared by the ALU blocks
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUBS = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational non-shift ALU datapath and the branch less-than flag
module alu_core import alu_pkg::*; (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        lt
);
  logic ltu, lts;
  assign ltu = a < b;
  assign lts = $signed(a) < $signed(b);
  assign lt  = op == ALU_SUBS ? lts : ltu;
  always_comb begin
    y = op == ALU_AND  ? a & b :
        op == ALU_OR   ? a | b :
        op == ALU_ADD  ? a + b :
        op == ALU_XOR  ? a ^ b :
        op == ALU_SUB || op == ALU_SUBS ? a - b :
        op == ALU_SLTU ? {31'd0, ltu} :
        op == ALU_SLT  ? {31'd0, lts} :
        op == ALU_LUI  ? b : 32'd0;
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with a bit-serial shifter; define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter
module alu_iter import alu_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Con_beq,
  input  logic        Con_bnq,
  input  logic        Con_blt,
  input  logic        Con_bgt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        BranchTaken,
  output logic        busy
);
  state_t state, nxt;
  logic [31:0] res, y, load, stepped;
  logic [3:0] con;
  logic lt, lt_q, fire, to_shift, last;
  alu_core u_core (.op(ALUControl), .a(SrcA), .b(SrcB), .y(y), .lt(lt));
  assign fire = in_valid && state == IDLE;
`ifdef ALU_FAST_SHIFT_EN
  logic [31:0] shifted;
  assign shifted  = ALUControl == ALU_SLL ? SrcA << SrcB[4:0] :
                    ALUControl == ALU_SRL ? SrcA >> SrcB[4:0] : $signed(SrcA) >>> SrcB[4:0];
  assign load     = is_shift(ALUControl) ? shifted : y;
  assign to_shift = 1'b0;
  assign last     = 1'b1;
  assign stepped  = res;
`else
  logic [4:0] cnt;
  logic [3:0] op_q;
  // shifts start from SrcA and move one bit per SHIFT cycle
  assign load     = is_shift(ALUControl) ? SrcA : y;
  assign to_shift = is_shift(ALUControl) && SrcB[4:0] != 5'd0;
  assign last     = cnt == 5'd1;
  assign stepped  = op_q == ALU_SLL ? {res[30:0], 1'b0} :
                    op_q == ALU_SRA ? {res[31], res[31:1]} : {1'b0, res[31:1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 5'd0;
      op_q <= 4'd0;
    end else if (fire) begin
      cnt  <= SrcB[4:0];
      op_q <= ALUControl;
    end else if (state == SHIFT) begin
      cnt  <= cnt - 5'd1;
    end
  end
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !in_valid ? IDLE : to_shift ? SHIFT : DONE;
      SHIFT:   nxt = last ? DONE : SHIFT;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      res   <= 32'd0;
      lt_q  <= 1'b0;
      con   <= 4'd0;
    end else begin
      state <= nxt;
      if (fire) begin
        res  <= load;
        lt_q <= lt;
        con  <= {Con_beq, Con_bnq, Con_blt, Con_bgt};
      end else if (state == SHIFT) begin
        res  <= stepped;
      end
    end
  end
  assign in_ready    = state == IDLE;
  assign out_valid   = state == DONE;
  assign busy        = state != IDLE;
  assign ALUResult   = res;
  // flags only mean something once the result is final
  assign Zero        = out_valid && res == 32'd0;
  assign BranchTaken = out_valid && ((con[3] && Zero) || (con[2] && !Zero) || (con[1] && lt_q) || (con[0] && !lt_q));
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter covering directed and random operations
module tb_alu_iter;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [3:0] ALUControl = 0;
  logic [31:0] SrcA = 0, SrcB = 0;
  logic Con_beq = 0, Con_bnq = 0, Con_blt = 0, Con_bgt = 0;
  logic in_ready, out_valid, Zero, BranchTaken, busy;
  logic [31:0] ALUResult;
  typedef struct packed {logic [31:0] res; logic zero; logic br; logic [5:0] lat;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [3:0] codes [13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                             4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1111};

  alu_iter dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .Con_beq(Con_beq), .Con_bnq(Con_bnq),
    .Con_blt(Con_blt), .Con_bgt(Con_bgt), .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .BranchTaken(BranchTaken), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] con);
    exp_t e;
    logic [31:0] r;
    logic lt, sh;
    sh = op == 4'b0100 || op == 4'b1000 || op == 4'b1100;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110, 4'b0111: r = a - b;
      4'b0101: r = {31'd0, a < b};
      4'b1010: r = {31'd0, $signed(a) < $signed(b)};
      4'b1001: r = b;
      4'b0100: r = a << b[4:0];
      4'b1000: r = a >> b[4:0];
      4'b1100: r = $signed(a) >>> b[4:0];
      default: r = 32'd0;
    endcase
    lt = op == 4'b0110 ? $signed(a) < $signed(b) : a < b;
    e.res  = r;
    e.zero = r == 32'd0;
    e.br   = (con[3] && e.zero) || (con[2] && !e.zero) || (con[1] && lt) || (con[0] && !lt);
`ifdef ALU_FAST_SHIFT_EN
    e.lat  = 6'd1;
`else
    e.lat  = sh ? 6'(b[4:0]) + 6'd1 : 6'd1;
`endif
    return e;
  endfunction

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] con, input int hold);
    exp_t e;
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    ALUControl = op; SrcA = a; SrcB = b;
    {Con_beq, Con_bnq, Con_blt, Con_bgt} = con;
    in_valid = 1;
    out_ready = hold == 0;
    sb.push_back(model(op, a, b, con));
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, 32'(e.lat));
    chk("result", ALUResult, e.res);
    chk("zero", Zero, e.zero);
    chk("branch", BranchTaken, e.br);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        ALUControl = 4'b0010; SrcA = 32'h1111; SrcB = 32'h2222;
        in_valid = 1;
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_result", ALUResult, e.res);
        chk("hold_zero", Zero, e.zero);
        chk("hold_branch", BranchTaken, e.br);
      end
      in_valid = 0;
      out_ready = 1;
    end
    @(negedge clk);
    chk("idle_after", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_branch", BranchTaken, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 0;
    run(4'b0010, 32'h7FFFFFFF, 32'd1, 4'b0000, 0);
    run(4'b0111, 32'h1234, 32'h1234, 4'b1000, 0);
    run(4'b0110, 32'hFFFFFFFF, 32'd1, 4'b0010, 0);
    run(4'b0111, 32'hFFFFFFFF, 32'd1, 4'b0010, 0);
    run(4'b1100, 32'h80000000, 32'd4, 4'b0000, 0);
    run(4'b1100, 32'h80000000, 32'd0, 4'b0000, 0);
    run(4'b0100, 32'h00000003, 32'd31, 4'b0100, 0);
    run(4'b1000, 32'h80000000, 32'd31, 4'b0001, 0);
    run(4'b0010, 32'd5, 32'd6, 4'b0001, 3);
    run(4'b1100, 32'h80000010, 32'd3, 4'b1000, 2);
    // abort a long shift partway through
    @(negedge clk);
    ALUControl = 4'b0100; SrcA = 32'h0000ABCD; SrcB = 32'd20; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
    chk("mid_shift_busy", busy, 1);
`endif
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", ALUResult, 0);
    chk("abort_in_ready", in_ready, 1);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort_stale", n, 0);
    for (int i = 0; i < 30; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = codes[$urandom_range(0, 12)];
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      run(op, a, b, 4'($urandom_range(0, 15)), i % 7 == 3 ? 1 : 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
